// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and interlock logic for the decode stage of the five-stage
// pipeline. For every ID source operand it picks the youngest in-flight
// producer (EXE > MEM > WB) to feed the operand-select mux. It stalls ID on
// load-use hazards and while the multi-cycle multiply/divide unit is busy.
// It also counts stalled cycles in a saturating counter for perf monitoring.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   id_valid             ID holds a valid instruction
//   id_src               NSRC packed register numbers, operand i at [i*AW +: AW]
//   id_src_used          per-operand "actually read" flags
//   id_is_md             ID instruction starts a multiply/divide
//   id_reads_hilo        ID instruction reads HI/LO
//   {exe,mem,wb}_valid   stage holds a valid instruction
//   {exe,mem,wb}_wdest   stage destination register
//   {exe,mem,wb}_rf_wen  stage writes the register file
//   exe_is_load          EXE instruction is a load
//   flush                exception/eret flush
//   fwd_sel              per-operand select: 00 regfile, 01 EXE, 10 MEM, 11 WB
//   id_stall             hold PC and IF/ID
//   exe_bubble           inject NOP into ID->EXE
//   md_busy              multiply/divide unit occupied
//   stall_cnt            saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int NSRC   = 2,
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 id_is_md,
  input  logic                 id_reads_hilo,
  input  logic                 exe_valid,
  input  logic                 mem_valid,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        exe_wdest,
  input  logic [AW-1:0]        mem_wdest,
  input  logic [AW-1:0]        wb_wdest,
  input  logic                 exe_rf_wen,
  input  logic                 mem_rf_wen,
  input  logic                 wb_rf_wen,
  input  logic                 exe_is_load,
  input  logic                 flush,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 id_stall,
  output logic                 exe_bubble,
  output logic                 md_busy,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int MDW = $clog2(MD_LAT + 1);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT);

  logic [NSRC-1:0] exe_hit;
  logic [NSRC-1:0] mem_hit;
  logic [NSRC-1:0] wb_hit;
  logic [MDW-1:0]  md_cnt;
  logic            load_stall;
  logic            md_stall;
  logic            md_issue;

  // Per-operand hit detection and producer selection. r0 is hard-wired to
  // zero, so a write to it is never a real producer.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] src;
    logic          live;

    assign src  = id_src[i*AW +: AW];
    assign live = id_src_used[i] & (src != '0);

    assign exe_hit[i] = live & exe_valid & exe_rf_wen & (exe_wdest == src);
    assign mem_hit[i] = live & mem_valid & mem_rf_wen & (mem_wdest == src);
    assign wb_hit[i]  = live & wb_valid  & wb_rf_wen  & (wb_wdest  == src);

    // Youngest producer wins: the EXE result supersedes older writes.
    assign fwd_sel[2*i +: 2] = exe_hit[i] ? 2'b01 :
                               mem_hit[i] ? 2'b10 :
                               wb_hit[i]  ? 2'b11 : 2'b00;
  end

  // Load data only exists from MEM onward, so an EXE hit on a load must wait.
  assign load_stall = exe_is_load & (|exe_hit);

  assign md_busy  = (md_cnt != '0);
  assign md_stall = id_valid & md_busy & (id_is_md | id_reads_hilo);

  // A flushed instruction is discarded anyway, so it never holds the pipe.
  assign id_stall   = id_valid & (load_stall | md_stall) & ~flush;
  assign exe_bubble = id_stall;

  assign md_issue = id_valid & id_is_md & ~id_stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      md_cnt <= '0;
    end else if (flush) begin
      // The in-flight op is abandoned; a same-cycle md issue is also killed.
      md_cnt <= '0;
    end else if (md_issue) begin
      md_cnt <= MD_LOAD;
    end else if (md_busy) begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
